// File: rtl/osd_pkg.sv
// Shared timing defaults, colour constants and pixel type for the OSD video source.
package osd_pkg;

  localparam int DEF_H_ACTIVE = 128;
  localparam int DEF_H_FP     = 4;
  localparam int DEF_H_SYNC   = 8;
  localparam int DEF_H_BP     = 12;
  localparam int DEF_V_ACTIVE = 96;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 4;
  localparam int DEF_OSD_X    = 16;
  localparam int DEF_OSD_Y    = 16;
  localparam int DEF_OSD_W    = 52;
  localparam int DEF_OSD_H    = 8;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t BLACK  = 12'h000;
  localparam rgb12_t WHITE  = 12'hFFF;
  localparam rgb12_t YELLOW = 12'hFF0;
  localparam rgb12_t OSD_BG = 12'h008;

  // 50/50 mix; each half is at most 7 so the sum never overflows a nibble.
  function automatic rgb12_t blend_half(input rgb12_t a, input rgb12_t b);
    rgb12_t o;
    o.r = (a.r >> 1) + (b.r >> 1);
    o.g = (a.g >> 1) + (b.g >> 1);
    o.b = (a.b >> 1) + (b.b >> 1);
    return o;
  endfunction

endpackage

// File: rtl/osd_timing_gen.sv
// Raster counters, frame counter and unregistered sync/data-enable decode.
module osd_timing_gen
  import osd_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          CLK,
  input  logic          RST,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic [7:0]    frame_cnt,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge CLK) begin
    if (RST) begin
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) begin
        v         <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        v <= v + VW'(1);
      end
    end else begin
      h <= h + HW'(1);
    end
  end

  assign hsync_n = !((h >= HS_START) && (h < HS_END));
  assign vsync_n = !((v >= VS_START) && (v < VS_END));
  assign de      = (h < H_ACT_L) && (v < V_ACT_L);

endmodule

// File: rtl/osd_top.sv
// OSD video source top: colour bars plus a bordered window showing the frame counter.
// Optional build macro OSD_BLEND_EN: window interior is a 50/50 mix with the bars.
module osd_top
  import osd_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int OSD_X    = DEF_OSD_X,
  parameter int OSD_Y    = DEF_OSD_Y,
  parameter int OSD_W    = DEF_OSD_W,
  parameter int OSD_H    = DEF_OSD_H
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       DE,
  output logic [3:0] RED,
  output logic [3:0] GREEN,
  output logic [3:0] BLUE
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);
  localparam logic [HW-1:0] WX0   = HW'(OSD_X);
  localparam logic [HW-1:0] WX1   = HW'(OSD_X + OSD_W - 1);
  localparam logic [VW-1:0] WY0   = VW'(OSD_Y);
  localparam logic [VW-1:0] WY1   = VW'(OSD_Y + OSD_H - 1);
  localparam logic [VW-1:0] BY0   = VW'(OSD_Y + 2);
  localparam logic [VW-1:0] BY1   = VW'(OSD_Y + 5);

  logic [HW-1:0] h_p0;
  logic [VW-1:0] v_p0;
  logic [7:0]    frame_cnt;
  logic          hsync_n_p0;
  logic          vsync_n_p0;
  logic          vld_p0;

  osd_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW),       .VW   (VW)
  ) u_timing (
    .CLK       (CLK),
    .RST       (RST),
    .h         (h_p0),
    .v         (v_p0),
    .frame_cnt (frame_cnt),
    .hsync_n   (hsync_n_p0),
    .vsync_n   (vsync_n_p0),
    .de        (vld_p0)
  );

  // Stage p0: pixel selection from the live counters
  logic [2:0]    bar_p0;
  rgb12_t        bg_p0;
  rgb12_t        interior_p0;
  rgb12_t        pix_p0;
  logic          in_win_p0;
  logic          border_p0;
  logic          lit_p0;
  logic [HW-1:0] bx;

  always_comb begin
    bar_p0      = 3'(h_p0 / BAR_W);
    bg_p0       = {{4{bar_p0[2]}}, {4{bar_p0[1]}}, {4{bar_p0[0]}}};
    in_win_p0   = (h_p0 >= WX0) && (h_p0 <= WX1) && (v_p0 >= WY0) && (v_p0 <= WY1);
    border_p0   = (h_p0 == WX0) || (h_p0 == WX1) || (v_p0 == WY0) || (v_p0 == WY1);
    lit_p0      = 1'b0;
    bx          = '0;
    // Block k shows frame_cnt[7-k], so the MSB sits at the left
    for (int k = 0; k < 8; k++) begin
      bx = HW'(OSD_X + 2 + 6 * k);
      if ((h_p0 >= bx) && (h_p0 <= bx + HW'(3)) && (v_p0 >= BY0) && (v_p0 <= BY1)
          && frame_cnt[3'(7 - k)])
        lit_p0 = 1'b1;
    end
`ifdef OSD_BLEND_EN
    interior_p0 = blend_half(bg_p0, OSD_BG);
`else
    interior_p0 = OSD_BG;
`endif
    if (!vld_p0)        pix_p0 = BLACK;
    else if (!in_win_p0) pix_p0 = bg_p0;
    else if (border_p0)  pix_p0 = WHITE;
    else if (lit_p0)     pix_p0 = YELLOW;
    else                 pix_p0 = interior_p0;
  end

  // Stage p1: registered video outputs
  rgb12_t pix_p1;
  logic   hsync_p1;
  logic   vsync_p1;
  logic   vld_p1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      vld_p1   <= 1'b0;
      pix_p1   <= BLACK;
    end else begin
      hsync_p1 <= hsync_n_p0;
      vsync_p1 <= vsync_n_p0;
      vld_p1   <= vld_p0;
      pix_p1   <= pix_p0;
    end
  end

  assign HSYNC = hsync_p1;
  assign VSYNC = vsync_p1;
  assign DE    = vld_p1;
  assign RED   = pix_p1.r;
  assign GREEN = pix_p1.g;
  assign BLUE  = pix_p1.b;

endmodule

// File: tb/tb_osd_top.sv
// Directed bench for osd_top: pixel vector table plus line/frame timing and mid-frame reset sequences.
module tb_osd_top;

  localparam int LINE  = 152;
  localparam int FRAME = 15808;

`ifdef OSD_BLEND_EN
  localparam logic [11:0] INT_B1 = 12'h00B;
  localparam logic [11:0] INT_B3 = 12'h07B;
`else
  localparam logic [11:0] INT_B1 = 12'h008;
  localparam logic [11:0] INT_B3 = 12'h008;
`endif

  logic       CLK;
  logic       RST;
  logic       HSYNC, VSYNC, DE;
  logic [3:0] RED, GREEN, BLUE;

  osd_top dut (
    .CLK   (CLK),
    .RST   (RST),
    .HSYNC (HSYNC),
    .VSYNC (VSYNC),
    .DE    (DE),
    .RED   (RED),
    .GREEN (GREEN),
    .BLUE  (BLUE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          fr;
    int          h;
    int          v;
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int fr, input int h, input int v, input logic de,
                     input logic hs, input logic vs, input logic [11:0] rgb);
    vec_t e;
    e.fr = fr; e.h = h; e.v = v; e.de = de; e.hs = hs; e.vs = vs; e.rgb = rgb;
    vecs.push_back(e);
  endtask

  // Outputs sampled after this step belong to raster position t
  task automatic step();
    @(posedge CLK);
    #1;
    t++;
  endtask

  task automatic advance_to(input int target);
    while (t < target) step();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, de_high, f1, f2, vs_low, prev, vf1, vf2;

    // fr, h, v, de, hs, vs, rgb -- sorted by raster time
    add(0,   0,   0, 1, 1, 1, 12'h000);
    add(0, 127,   0, 1, 1, 1, 12'hFFF);
    add(0, 128,   0, 0, 1, 1, 12'h000);
    add(0, 131,   5, 0, 1, 1, 12'h000);
    add(0, 132,   5, 0, 0, 1, 12'h000);
    add(0, 139,   5, 0, 0, 1, 12'h000);
    add(0, 140,   5, 0, 1, 1, 12'h000);
    add(0,  16,  16, 1, 1, 1, 12'hFFF);
    add(0,  18,  18, 1, 1, 1, INT_B1);
    add(0,  30,  20, 1, 1, 1, INT_B1);
    add(0,  67,  20, 1, 1, 1, 12'hFFF);
    add(0,  68,  20, 1, 1, 1, 12'hF00);
    add(0,  20,  23, 1, 1, 1, 12'hFFF);
    add(0,  20,  24, 1, 1, 1, 12'h00F);
    add(0,  40,  50, 1, 1, 1, 12'h0F0);
    add(0,  10,  98, 0, 1, 0, 12'h000);
    add(0,  10, 100, 0, 1, 1, 12'h000);
    add(1,  55,  19, 1, 1, 1, INT_B3);
    add(1,  63,  19, 1, 1, 1, 12'hFF0);
    add(1, 151, 103, 0, 1, 1, 12'h000);
    add(2,  49,  19, 1, 1, 1, INT_B3);
    add(2,  55,  19, 1, 1, 1, 12'hFF0);
    add(2,  63,  19, 1, 1, 1, INT_B3);

    RST = 1'b1;
    t = -1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("reset_hsync", HSYNC, 1);
    chk("reset_vsync", VSYNC, 1);
    chk("reset_de", DE, 0);
    chk("reset_rgb", {RED, GREEN, BLUE}, 12'h000);
    RST = 1'b0;
    step();

    foreach (vecs[i]) begin
      advance_to(vecs[i].fr * FRAME + vecs[i].v * LINE + vecs[i].h);
      chk($sformatf("vec%0d_f%0d_(%0d,%0d)_de", i, vecs[i].fr, vecs[i].h, vecs[i].v), DE, vecs[i].de);
      chk($sformatf("vec%0d_f%0d_(%0d,%0d)_hsync", i, vecs[i].fr, vecs[i].h, vecs[i].v), HSYNC, vecs[i].hs);
      chk($sformatf("vec%0d_f%0d_(%0d,%0d)_vsync", i, vecs[i].fr, vecs[i].h, vecs[i].v), VSYNC, vecs[i].vs);
      chk($sformatf("vec%0d_f%0d_(%0d,%0d)_rgb", i, vecs[i].fr, vecs[i].h, vecs[i].v), {RED, GREEN, BLUE}, vecs[i].rgb);
    end

    // Mid-frame reset: counters hold (70,40) when RST is sampled
    advance_to(2 * FRAME + 40 * LINE + 69);
    RST = 1'b1;
    step();
    chk("midrst_hsync", HSYNC, 1);
    chk("midrst_vsync", VSYNC, 1);
    chk("midrst_de", DE, 0);
    chk("midrst_rgb", {RED, GREEN, BLUE}, 12'h000);
    RST = 1'b0;
    step();
    t = 0;
    chk("restart_de", DE, 1);
    chk("restart_hsync", HSYNC, 1);
    chk("restart_rgb", {RED, GREEN, BLUE}, 12'h000);
    advance_to(19 * LINE + 55);
    chk("restart_frame0_block", {RED, GREEN, BLUE}, INT_B3);

    // One full line: sync width and active width
    advance_to(20 * LINE);
    hs_low = 0;
    de_high = 0;
    for (int i = 0; i < LINE; i++) begin
      if (!HSYNC) hs_low++;
      if (DE) de_high++;
      step();
    end
    chk("hsync_low_clocks", hs_low, 8);
    chk("de_high_clocks", de_high, 128);

    // HSYNC period between two falling edges
    f1 = -1;
    f2 = -1;
    prev = HSYNC;
    for (int i = 0; i < 400 && f2 < 0; i++) begin
      step();
      if (prev == 1 && HSYNC == 0) begin
        if (f1 < 0) f1 = t;
        else f2 = t;
      end
      prev = HSYNC;
    end
    chk("hsync_period", (f1 >= 0 && f2 >= 0) ? f2 - f1 : -1, LINE);

    // VSYNC width and period
    vf1 = -1;
    vf2 = -1;
    vs_low = 0;
    prev = VSYNC;
    for (int i = 0; i < 2 * FRAME && vf2 < 0; i++) begin
      step();
      if (prev == 1 && VSYNC == 0) begin
        if (vf1 < 0) vf1 = t;
        else vf2 = t;
      end
      if (vf1 >= 0 && vf2 < 0 && !VSYNC) vs_low++;
      prev = VSYNC;
    end
    chk("vsync_period", (vf1 >= 0 && vf2 >= 0) ? vf2 - vf1 : -1, FRAME);
    chk("vsync_low_clocks", vs_low, 2 * LINE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
